// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared 7-segment definitions for the multiplexed 4-digit display link.
//   Glyphs are active-high {a,b,c,d,e,f,g} with bit 6 = a. The display
//   driver and the scan capture block both draw from this single table so
//   the two ends of the link always agree on the character set.
//   Contents: NUM_DIGITS, GLYPH_0..GLYPH_F, scan_sample_t, hex_glyph().
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] GLYPH_0 = 7'h7E;  // abcdef
  localparam logic [6:0] GLYPH_1 = 7'h30;  // bc
  localparam logic [6:0] GLYPH_2 = 7'h6D;  // abdeg
  localparam logic [6:0] GLYPH_3 = 7'h79;  // abcdg
  localparam logic [6:0] GLYPH_4 = 7'h33;  // bcfg
  localparam logic [6:0] GLYPH_5 = 7'h5B;  // acdfg
  localparam logic [6:0] GLYPH_6 = 7'h5F;  // acdefg
  localparam logic [6:0] GLYPH_7 = 7'h70;  // abc
  localparam logic [6:0] GLYPH_8 = 7'h7F;  // abcdefg
  localparam logic [6:0] GLYPH_9 = 7'h7B;  // abcdfg
  localparam logic [6:0] GLYPH_A = 7'h77;  // abcefg
  localparam logic [6:0] GLYPH_B = 7'h1F;  // cdefg  (lower-case b)
  localparam logic [6:0] GLYPH_C = 7'h4E;  // adef
  localparam logic [6:0] GLYPH_D = 7'h3D;  // bcdeg  (lower-case d)
  localparam logic [6:0] GLYPH_E = 7'h4F;  // adefg
  localparam logic [6:0] GLYPH_F = 7'h47;  // aefg

  // One sample of the scanned bus, exactly as seen on the pins (active-low).
  typedef struct packed {
    logic [NUM_DIGITS-1:0] dout_n;
    logic [6:0]            seg_n;
  } scan_sample_t;

  // Glyph for a hex value.
  function automatic logic [6:0] hex_glyph(input logic [3:0] value);
    logic [6:0] glyph;
    case (value)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex
//   Combinational reverse lookup of an active-high 7-segment glyph.
//   Ports:
//     i_glyph  in  7  active-high {a..g}, bit 6 = a
//     o_value  out 4  hex value of the glyph (0 when not legal)
//     o_legal  out 1  glyph matches one of the sixteen hex characters
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] i_glyph,
  output logic [3:0] o_value,
  output logic       o_legal
);

  logic [15:0] w_match;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_match
      assign w_match[gi] = (i_glyph == hex_glyph(4'(gi)));
    end
  endgenerate

  // All sixteen glyphs are distinct, so at most one match bit is set and
  // the encoder needs no priority.
  always_comb begin
    o_value = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_match[i]) o_value = 4'(i);
    end
  end

  assign o_legal = |w_match;

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Receive side of the multiplexed 4-digit 7-segment link. Registers the
//   scanned bus, waits for a pattern to stay unchanged for STABLE_CYCLES
//   samples, then decodes the selected digit back to a hex value.
//   Ports:
//     clk         in  1  system clock
//     rst         in  1  synchronous reset, active-high
//     dout_n      in  4  digit enables, active-low one-hot
//     seg_n       in  7  segments a..g, active-low, seg_n[6] = a
//     d0..d3      out 4  last captured hex value per digit
//     valid       out 4  digit decoded since the last frame boundary
//     seg_err     out 1  pulse: stable pattern is not a hex glyph
//     frame_done  out 1  pulse: all four digits captured
//   Pipeline: sample edge -> capture edge (run reaches STABLE_CYCLES)
//   -> output edge (decode result lands in d/valid/seg_err).
module seg_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dout_n,
  input  logic [6:0] seg_n,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] valid,
  output logic       seg_err,
  output logic       frame_done
);

  // Keep the run target inside what the 4-bit counter can represent.
  localparam int RUN_TARGET = (STABLE_CYCLES < 1)  ? 1 :
                              (STABLE_CYCLES > 15) ? 15 : STABLE_CYCLES;
  localparam logic [3:0] RUN_MAX = 4'(RUN_TARGET);

  // ---------------- input stage and run counter ----------------
  scan_sample_t w_sample_in;
  scan_sample_t r_sample;
  logic [3:0]   r_run;
  logic [3:0]   w_run_next;
  logic         w_same;
  logic         w_capture;
  logic [3:0]   w_en;
  logic         w_onehot;

  assign w_sample_in = '{dout_n: dout_n, seg_n: seg_n};
  assign w_same      = (w_sample_in == r_sample);

  always_comb begin
    w_run_next = 4'd1;
    if (w_same) begin
      w_run_next = (r_run == RUN_MAX) ? r_run : r_run + 4'd1;
    end
  end

  // Fire only on the transition into RUN_MAX; a run that has already
  // saturated keeps r_run == RUN_MAX and must not capture again.
  assign w_capture = (w_run_next == RUN_MAX) && !(w_same && (r_run == RUN_MAX));

  assign w_en     = ~dout_n;
  assign w_onehot = (w_en != 4'd0) && ((w_en & (w_en - 4'd1)) == 4'd0);

  scan_sample_t r_cap_sample;
  logic         r_cap_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample     <= '1;
      r_run        <= 4'd0;
      r_cap_valid  <= 1'b0;
      r_cap_sample <= '1;
    end else begin
      r_sample    <= w_sample_in;
      r_run       <= w_run_next;
      // Idle or multi-select enables never reach the decoder.
      r_cap_valid <= w_capture && w_onehot;
      if (w_capture) r_cap_sample <= w_sample_in;
    end
  end

  // ---------------- decode ----------------
  logic [3:0] w_value;
  logic       w_legal;
  logic [3:0] w_cap_sel;

  seg7_to_hex u_decode (
    .i_glyph (~r_cap_sample.seg_n),
    .o_value (w_value),
    .o_legal (w_legal)
  );

  assign w_cap_sel = ~r_cap_sample.dout_n;

  // ---------------- per-digit value registers ----------------
  logic [NUM_DIGITS-1:0][3:0] w_digit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] r_val;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_val <= 4'd0;
        end else if (r_cap_valid && w_cap_sel[gi] && w_legal) begin
          r_val <= w_value;
        end
      end
      assign w_digit[gi] = r_val;
    end
  endgenerate

  assign d0 = w_digit[0];
  assign d1 = w_digit[1];
  assign d2 = w_digit[2];
  assign d3 = w_digit[3];

  // ---------------- mask, valid and frame tracking ----------------
  logic [3:0] r_mask;
  logic [3:0] r_valid;
  logic       r_seg_err;
  logic       r_frame_done;
  logic       w_frame_full;
  logic [3:0] w_mask_next;
  logic [3:0] w_valid_next;
  logic       w_err_next;

  assign w_frame_full = (r_mask == 4'hF);

  // A full mask is retired on this edge; a capture landing on the same edge
  // is applied on top of the cleared mask so it counts toward the next frame.
  always_comb begin
    w_mask_next  = w_frame_full ? 4'd0 : r_mask;
    w_valid_next = w_frame_full ? 4'd0 : r_valid;
    w_err_next   = 1'b0;
    if (r_cap_valid) begin
      if (w_legal) begin
        w_mask_next  = w_mask_next | w_cap_sel;
        w_valid_next = w_valid_next | w_cap_sel;
      end else begin
        w_valid_next = w_valid_next & ~w_cap_sel;
        w_err_next   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask       <= 4'd0;
      r_valid      <= 4'd0;
      r_seg_err    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_mask       <= w_mask_next;
      r_valid      <= w_valid_next;
      r_seg_err    <= w_err_next;
      r_frame_done <= w_frame_full;
    end
  end

  assign valid      = r_valid;
  assign seg_err    = r_seg_err;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dout_n;
  logic [6:0] seg_n;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] valid;
  logic       seg_err;
  logic       frame_done;

  always #5 clk = ~clk;

  seg_scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .dout_n     (dout_n),
    .seg_n      (seg_n),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .valid      (valid),
    .seg_err    (seg_err),
    .frame_done (frame_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Active-high glyphs written out from the segment letter lists.
  logic [6:0] glyph_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // ---------------- behavioural model ----------------
  // A digit is captured when the last S samples are identical and the run
  // began exactly S samples ago; its result appears one edge later.
  logic [3:0]  m_d [4];
  logic [3:0]  m_valid, m_mask;
  logic        m_err, m_frame;
  logic [10:0] m_hist [16];
  int          m_n;
  logic        m_pend;
  logic [10:0] m_pend_s;
  bit          model_on = 0;

  always @(posedge clk) begin : model
    logic [10:0] cur;
    logic        same;
    logic        found;
    int          dig;
    int          val;
    cur = {dout_n, seg_n};
    if (rst) begin
      for (int i = 0; i < 4; i++) m_d[i] = 4'd0;
      m_valid = 4'd0; m_mask = 4'd0; m_err = 1'b0; m_frame = 1'b0;
      m_n = 0; m_pend = 1'b0; m_pend_s = '1;
      model_on = 1;
    end else begin
      m_frame = (m_mask == 4'hF);
      if (m_frame) begin
        m_mask = 4'd0;
        m_valid = 4'd0;
      end
      m_err = 1'b0;
      if (m_pend) begin
        dig = 0;
        for (int i = 0; i < 4; i++) if (!m_pend_s[7+i]) dig = i;
        found = 1'b0; val = 0;
        for (int v = 0; v < 16; v++) if (glyph_tab[v] == ~m_pend_s[6:0]) begin found = 1'b1; val = v; end
        if (found) begin
          m_d[dig] = 4'(val);
          m_valid[dig] = 1'b1;
          m_mask[dig] = 1'b1;
        end else begin
          m_valid[dig] = 1'b0;
          m_err = 1'b1;
        end
      end
      for (int i = 15; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = cur;
      if (m_n < 100) m_n++;
      m_pend = 1'b0;
      if (m_n >= S) begin
        same = 1'b1;
        for (int i = 0; i < S; i++) if (m_hist[i] != cur) same = 1'b0;
        if (same && (m_n == S || m_hist[S] != cur) && ($countones(~cur[10:7]) == 1)) begin
          m_pend = 1'b1;
          m_pend_s = cur;
        end
      end
    end
  end

  // ---------------- per-cycle compare and event counters ----------------
  int   cnt_frame = 0;
  int   cnt_err = 0;
  bit   saw_d1_3 = 0;
  logic [3:0] fd_valid = 4'hF;

  always @(negedge clk) begin
    if (model_on) begin
      chk("cyc d0", d0, m_d[0]);
      chk("cyc d1", d1, m_d[1]);
      chk("cyc d2", d2, m_d[2]);
      chk("cyc d3", d3, m_d[3]);
      chk("cyc valid", valid, m_valid);
      chk("cyc seg_err", seg_err, m_err);
      chk("cyc frame_done", frame_done, m_frame);
      if (frame_done) begin cnt_frame++; fd_valid = valid; end
      if (seg_err) cnt_err++;
      if (d1 == 4'h3) saw_d1_3 = 1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic hold(input logic [3:0] dn, input logic [6:0] sn, input int n);
    dout_n = dn;
    seg_n  = sn;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " d0"}, d0, 4'd0);
    chk({tag, " d1"}, d1, 4'd0);
    chk({tag, " d2"}, d2, 4'd0);
    chk({tag, " d3"}, d3, 4'd0);
    chk({tag, " valid"}, valid, 4'd0);
    chk({tag, " seg_err"}, seg_err, 1'b0);
    chk({tag, " frame_done"}, frame_done, 1'b0);
  endtask

  logic [3:0] s_d0, s_d1, s_d2, s_d3, s_valid;

  initial begin
    rst = 1'b1; dout_n = 4'hF; seg_n = 7'h7F;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    $display("reset: outputs d=%h%h%h%h valid=%b", d3, d2, d1, d0, valid);

    // 1: single stable glyph 0 on digit 0
    hold(4'b1110, 7'b0000001, 2);
    chk("s1 valid before latency", valid, 4'b0000);
    hold(4'b1110, 7'b0000001, 1);
    chk("s1 valid", valid, 4'b0001);
    chk("s1 d0", d0, 4'h0);
    chk("s1 seg_err", seg_err, 1'b0);
    $display("s1: glyph0 on digit0 -> d0=%h valid=%b", d0, valid);

    // 2: full scan 1, A, C, F
    cnt_frame = 0; fd_valid = 4'hF;
    hold(4'b1110, 7'b1001111, 4);
    hold(4'b1101, 7'b0001000, 4);
    hold(4'b1011, 7'b0110001, 4);
    hold(4'b0111, 7'b0111000, 4);
    hold(4'b1111, 7'b1111111, 4);
    chk("s2 d0", d0, 4'h1);
    chk("s2 d1", d1, 4'hA);
    chk("s2 d2", d2, 4'hC);
    chk("s2 d3", d3, 4'hF);
    chk("s2 frame count", cnt_frame, 1);
    chk("s2 valid at frame_done", fd_valid, 4'b0000);
    chk("s2 valid after", valid, 4'b0000);
    $display("s2: scan -> d=%h%h%h%h frames=%0d", d3, d2, d1, d0, cnt_frame);

    // 3: enable moves one cycle before segments
    saw_d1_3 = 0;
    hold(4'b1110, 7'b0000110, 4);
    hold(4'b1101, 7'b0000110, 1);
    hold(4'b1101, 7'b0001111, 4);
    hold(4'b1111, 7'b1111111, 3);
    chk("s3 d0", d0, 4'h3);
    chk("s3 d1", d1, 4'h7);
    chk("s3 skew glyph captured", saw_d1_3, 1'b0);
    $display("s3: skew -> d0=%h d1=%h", d0, d1);

    // 4: illegal glyph (g only) on digit 2
    cnt_err = 0; cnt_frame = 0;
    hold(4'b1011, 7'b1111110, 4);
    hold(4'b1111, 7'b1111111, 3);
    chk("s4 seg_err count", cnt_err, 1);
    chk("s4 d2", d2, 4'hC);
    chk("s4 valid2", valid[2], 1'b0);
    chk("s4 frame count", cnt_frame, 0);
    $display("s4: illegal glyph -> errs=%0d d2=%h valid=%b", cnt_err, d2, valid);

    // 5: multi-select and idle enables ignored
    s_d0 = d0; s_d1 = d1; s_d2 = d2; s_d3 = d3; s_valid = valid;
    cnt_err = 0;
    hold(4'b1100, 7'b0000000, 4);
    hold(4'b1111, 7'b0000000, 4);
    chk("s5 d0", d0, s_d0);
    chk("s5 d1", d1, s_d1);
    chk("s5 d2", d2, s_d2);
    chk("s5 d3", d3, s_d3);
    chk("s5 valid", valid, 4'b0011);
    chk("s5 seg_err count", cnt_err, 0);
    $display("s5: bad enables -> d=%h%h%h%h valid=%b", d3, d2, d1, d0, valid);
    if (s_valid != valid) $display("s5: valid moved from %b", s_valid);

    // 6: reset with a capture pending, then a clean scan
    hold(4'b1110, 7'b0100100, 4);
    hold(4'b1101, 7'b0000100, 2);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("s6 reset");
    rst = 1'b0;
    cnt_frame = 0;
    hold(4'b1110, 7'b0100100, 4);
    hold(4'b1101, 7'b0000100, 4);
    hold(4'b1011, 7'b0010010, 4);
    hold(4'b0111, 7'b1100000, 4);
    hold(4'b1111, 7'b1111111, 4);
    chk("s6 d0", d0, 4'h5);
    chk("s6 d1", d1, 4'h9);
    chk("s6 d2", d2, 4'h2);
    chk("s6 d3", d3, 4'hB);
    chk("s6 frame count", cnt_frame, 1);
    $display("s6: reset+rescan -> d=%h%h%h%h frames=%0d", d3, d2, d1, d0, cnt_frame);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
